mul_share_arbiter: RTL and testbench

- Shares one combinational four_bit_signed_multiplier between NUM_REQ requesters in the calculator datapath.
- Each requester has a valid/ready request channel. The block arbitrates round-robin, latches the winning operands and registers the signed product.
- The product is returned on one shared response channel, tagged with the requester id and subject to backpressure.
- Sits between the calculator front-end ports and the multiplier datapath.

---
 rtl/mul_share_pkg.sv | 36 +++
 rtl/eight_bit_adder.sv | 11 +
 rtl/four_bit_signed_multiplier.sv | 42 ++++
 rtl/mul_share_arbiter.sv | 110 +++++++++++
 tb/tb_mul_share_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_share_pkg.sv
// Shared types, widths and the round-robin pick used by the multiplier-sharing arbiter.
package mul_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int OP_W     = 4;
    localparam int PROD_W   = 8;
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    // First set bit of valid searching upward from last+1, wrapping at num_req.
    function automatic logic [MAX_ID_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] last,
        input int                  num_req
    );
        logic [MAX_ID_W-1:0] pick;
        logic [MAX_ID_W-1:0] idx;
        logic                found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = MAX_ID_W'((int'(last) + k) % num_req);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/eight_bit_adder.sv
// Eight-bit ripple adder with carry-in, used by the signed multiplier's partial-product tree.
module eight_bit_adder (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o
);

    assign sum_o = a_i + b_i + {7'd0, cin_i};

endmodule

// File: rtl/four_bit_signed_multiplier.sv
// Combinational 4x4 two's-complement multiplier; the MSB partial product carries weight -8,
// so it is added as its one's complement with a carry-in of one.
module four_bit_signed_multiplier
    import mul_share_pkg::*;
(
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [PROD_W-1:0] product_o
);

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] pp  [OP_W];
    logic [PROD_W-1:0] acc [OP_W+1];

    assign a_ext  = {{(PROD_W-OP_W){a_i[OP_W-1]}}, a_i};
    assign acc[0] = '0;

    generate
        for (genvar gi = 0; gi < OP_W; gi++) begin : g_pp
            if (gi == OP_W-1) begin : g_neg
                assign pp[gi] = b_i[gi] ? ~(a_ext << gi) : '0;
                eight_bit_adder u_add (
                    .a_i   (acc[gi]),
                    .b_i   (pp[gi]),
                    .cin_i (b_i[gi]),
                    .sum_o (acc[gi+1])
                );
            end else begin : g_pos
                assign pp[gi] = b_i[gi] ? (a_ext << gi) : '0;
                eight_bit_adder u_add (
                    .a_i   (acc[gi]),
                    .b_i   (pp[gi]),
                    .cin_i (1'b0),
                    .sum_o (acc[gi+1])
                );
            end
        end
    endgenerate

    assign product_o = acc[OP_W];

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one signed 4x4 multiplier among NUM_REQ requesters,
// with a registered, id-tagged response channel that honours backpressure.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*OP_W-1:0]       rsp_product,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);

    state_t              state_q;
    logic [ID_W-1:0]     last_grant_q;
    logic [ID_W-1:0]     id_q;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic                rsp_valid_q;
    logic [PROD_W-1:0]   rsp_product_q;
    logic [ID_W-1:0]     rsp_id_q;

    logic [MAX_REQ-1:0]  valid_ext;
    logic [MAX_ID_W-1:0] last_ext;
    logic [ID_W-1:0]     grant;
    logic                grant_en;
    logic [PROD_W-1:0]   product;
    logic [OP_W-1:0]     a_slice [NUM_REQ];
    logic [OP_W-1:0]     b_slice [NUM_REQ];

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
        last_ext                 = '0;
        last_ext[ID_W-1:0]       = last_grant_q;
    end

    assign grant    = ID_W'(rr_pick(valid_ext, last_ext, NUM_REQ));
    // Gated by rst_n so no accept can leak out while reset is held.
    assign grant_en = rst_n && (state_q == IDLE) && (|req_valid);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign a_slice[gi]   = req_a[gi*OP_W +: OP_W];
            assign b_slice[gi]   = req_b[gi*OP_W +: OP_W];
            assign req_ready[gi] = grant_en && (grant == ID_W'(gi));
        end
    endgenerate

    four_bit_signed_multiplier u_mul (
        .a_i       (a_q),
        .b_i       (b_q),
        .product_o (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= ID_W'(NUM_REQ-1);
            id_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_product_q <= '0;
            rsp_id_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        a_q          <= a_slice[grant];
                        b_q          <= b_slice[grant];
                        id_q         <= grant;
                        last_grant_q <= grant;
                        state_q      <= CALC;
                    end
                end
                CALC: begin
                    rsp_product_q <= product;
                    rsp_id_q      <= id_q;
                    rsp_valid_q   <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = rsp_product_q;
    assign rsp_id      = rsp_id_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scenario bench for mul_share_arbiter: directed cases plus randomized traffic against a
// round-robin / signed-arithmetic reference model.
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
    localparam int OP_W    = 4;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*OP_W-1:0] req_a;
    logic [NUM_REQ*OP_W-1:0] req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [2*OP_W-1:0]       rsp_product;
    logic [ID_W-1:0]         rsp_id;
    logic                    busy;

    int vectors     = 0;
    int miscompares = 0;
    int rr_last     = NUM_REQ - 1;

    mul_share_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_pick(input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (rr_last + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_prod(input logic [3:0] a, input logic [3:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return 8'(p);
    endfunction

    task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[i*OP_W +: OP_W] = a;
        req_b[i*OP_W +: OP_W] = b;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b01;
        @(negedge clk);
        #1;
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        vectors++; if (rsp_product !== 8'h00) begin miscompares++; $display("FAIL reset_rsp_product got %h exp 00", rsp_product); end
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        req_valid = '0;
        @(negedge clk);
        rst_n   = 1'b1;
        rr_last = NUM_REQ - 1;
    endtask

    task automatic test_single();
        int         g;
        logic [7:0] e;
        set_ops(0, 4'hD, 4'h9);
        req_valid = 2'b01;
        g = model_pick(req_valid);
        e = model_prod(4'hD, 4'h9);
        rr_last = g;
        #1;
        vectors++; if (req_ready !== NUM_REQ'(1 << g)) begin miscompares++; $display("FAIL single_grant got %b exp %b", req_ready, NUM_REQ'(1 << g)); end
        @(negedge clk);
        req_valid = '0;
        #1;
        vectors++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin miscompares++; $display("FAIL single_calc busy=%b rsp_valid=%b ready=%b exp 1 0 00", busy, rsp_valid, req_ready); end
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b1 || rsp_product !== e || rsp_id !== ID_W'(g)) begin miscompares++; $display("FAIL single_rsp got v=%b p=%h id=%0d exp 1 %h %0d", rsp_valid, rsp_product, rsp_id, e, g); end
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_done got v=%b busy=%b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_contention();
        int         g;
        logic [7:0] e;
        set_ops(0, 4'd3, 4'd5);
        set_ops(1, 4'hE, 4'd6);
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            g = model_pick(req_valid);
            e = (g == 0) ? model_prod(4'd3, 4'd5) : model_prod(4'hE, 4'd6);
            rr_last = g;
            #1;
            vectors++; if (req_ready !== NUM_REQ'(1 << g)) begin miscompares++; $display("FAIL contention_grant%0d got %b exp %b", n, req_ready, NUM_REQ'(1 << g)); end
            @(negedge clk);
            vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL contention_calc_ready%0d got %b exp 00", n, req_ready); end
            @(negedge clk);
            vectors++; if (rsp_valid !== 1'b1 || rsp_product !== e || rsp_id !== ID_W'(g)) begin miscompares++; $display("FAIL contention_rsp%0d got v=%b p=%h id=%0d exp 1 %h %0d", n, rsp_valid, rsp_product, rsp_id, e, g); end
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL contention_idle got v=%b busy=%b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_backpressure();
        int         g;
        logic [7:0] e;
        set_ops(0, 4'd4, 4'hB);
        set_ops(1, 4'd1, 4'd1);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        g = model_pick(req_valid);
        e = model_prod(4'd4, 4'hB);
        rr_last = g;
        #1;
        vectors++; if (req_ready !== NUM_REQ'(1 << g)) begin miscompares++; $display("FAIL bp_grant got %b exp %b", req_ready, NUM_REQ'(1 << g)); end
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            #1;
            vectors++; if (rsp_valid !== 1'b1 || rsp_product !== e || rsp_id !== ID_W'(g) || busy !== 1'b1 || req_ready !== 2'b00) begin
                miscompares++; $display("FAIL bp_hold%0d got v=%b p=%h id=%0d busy=%b ready=%b exp 1 %h %0d 1 00", s, rsp_valid, rsp_product, rsp_id, busy, req_ready, e, g);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL bp_release got v=%b busy=%b exp 0 0", rsp_valid, busy); end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_extremes();
        logic [3:0] ta [4];
        logic [3:0] tbv [4];
        logic [7:0] e;
        int         g;
        ta  = '{4'h8, 4'h8, 4'h7, 4'h0};
        tbv = '{4'h8, 4'h3, 4'h7, 4'hA};
        rsp_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            set_ops(0, ta[n], tbv[n]);
            req_valid = 2'b01;
            g = model_pick(req_valid);
            e = model_prod(ta[n], tbv[n]);
            rr_last = g;
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            vectors++; if (rsp_valid !== 1'b1 || rsp_product !== e) begin miscompares++; $display("FAIL extreme%0d a=%h b=%h got v=%b p=%h exp 1 %h", n, ta[n], tbv[n], rsp_valid, rsp_product, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midop();
        int         g;
        logic [7:0] e;
        set_ops(0, 4'd2, 4'd3);
        set_ops(1, 4'd5, 4'hF);
        req_valid = 2'b01;
        g = model_pick(req_valid);
        rr_last = g;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin miscompares++; $display("FAIL midreset_immediate got v=%b busy=%b ready=%b exp 0 0 00", rsp_valid, busy, req_ready); end
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        rr_last = NUM_REQ - 1;
        #1;
        vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset_no_rsp got v=%b busy=%b exp 0 0", rsp_valid, busy); end
        req_valid = 2'b11;
        g = model_pick(req_valid);
        e = (g == 0) ? model_prod(4'd2, 4'd3) : model_prod(4'd5, 4'hF);
        rr_last = g;
        #1;
        vectors++; if (req_ready !== NUM_REQ'(1 << g)) begin miscompares++; $display("FAIL midreset_ptr got %b exp %b", req_ready, NUM_REQ'(1 << g)); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        vectors++; if (rsp_product !== e || rsp_id !== ID_W'(g)) begin miscompares++; $display("FAIL midreset_rsp got p=%h id=%0d exp %h %0d", rsp_product, rsp_id, e, g); end
        @(negedge clk);
        req_valid = 2'b10;
        g = model_pick(req_valid);
        e = model_prod(4'd5, 4'hF);
        rr_last = g;
        #1;
        vectors++; if (req_ready !== NUM_REQ'(1 << g)) begin miscompares++; $display("FAIL midreset_req1 got %b exp %b", req_ready, NUM_REQ'(1 << g)); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        vectors++; if (rsp_product !== e || rsp_id !== ID_W'(g)) begin miscompares++; $display("FAIL midreset_req1_rsp got p=%h id=%0d exp %h %0d", rsp_product, rsp_id, e, g); end
        @(negedge clk);
    endtask

    task automatic test_operand_change();
        int         g;
        logic [7:0] e;
        set_ops(1, 4'd2, 4'hD);
        req_valid = 2'b10;
        g = model_pick(req_valid);
        e = model_prod(4'd2, 4'hD);
        rr_last = g;
        @(negedge clk);
        set_ops(1, 4'd7, 4'd7);
        req_valid = '0;
        @(negedge clk);
        vectors++; if (rsp_product !== e || rsp_id !== ID_W'(g)) begin miscompares++; $display("FAIL opchange got p=%h id=%0d exp %h %0d", rsp_product, rsp_id, e, g); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int                 g;
        int                 stall;
        logic [7:0]         e;
        logic [NUM_REQ-1:0] v;
        for (int n = 0; n < 60; n++) begin
            v         = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            req_valid = v;
            req_a     = (NUM_REQ*OP_W)'($urandom);
            req_b     = (NUM_REQ*OP_W)'($urandom);
            rsp_ready = 1'b1;
            #1;
            if (v == '0) begin
                vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL rand%0d_idle_ready got %b exp 00", n, req_ready); end
                @(negedge clk);
                continue;
            end
            g = model_pick(v);
            e = model_prod(req_a[g*OP_W +: OP_W], req_b[g*OP_W +: OP_W]);
            rr_last = g;
            vectors++; if (req_ready !== NUM_REQ'(1 << g)) begin miscompares++; $display("FAIL rand%0d_grant v=%b got %b exp %b", n, v, req_ready, NUM_REQ'(1 << g)); end
            @(negedge clk);
            req_valid = NUM_REQ'($urandom);
            req_a     = (NUM_REQ*OP_W)'($urandom);
            req_b     = (NUM_REQ*OP_W)'($urandom);
            stall     = $urandom_range(0, 3);
            #1;
            vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL rand%0d_calc_ready got %b exp 00", n, req_ready); end
            @(negedge clk);
            for (int s = 0; s <= stall; s++) begin
                rsp_ready = (s == stall);
                #1;
                vectors++; if (rsp_valid !== 1'b1 || rsp_product !== e || rsp_id !== ID_W'(g) || req_ready !== 2'b00) begin
                    miscompares++; $display("FAIL rand%0d_rsp%0d got v=%b p=%h id=%0d ready=%b exp 1 %h %0d 00", n, s, rsp_valid, rsp_product, rsp_id, req_ready, e, g);
                end
                @(negedge clk);
            end
            #1;
            vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rand%0d_done got v=%b busy=%b exp 0 0", n, rsp_valid, busy); end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_extremes();
        test_reset_midop();
        test_operand_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
